// File: rtl/types_pkg.sv
// Shared types for the scenario scheduler: sequence table entry, scheduler states and
// the input/output bundles exchanged with the top level and the scenario FSMs.
package types_pkg;

    localparam int SCEN_ID_W = 8;
    localparam int REPEAT_W  = 8;

    typedef struct packed {
        logic start;
    } input_signals_t;

    typedef struct packed {
        logic       output_trigger;
        logic [7:0] scenario_state;
        logic       valid_scenario;
    } output_signals_t;

    typedef struct packed {
        logic [SCEN_ID_W-1:0] scen_id;
        logic [REPEAT_W-1:0]  rpt;
    } seq_entry_t;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ARMED     = 4'd1,
        S_LOAD      = 4'd2,
        S_LAUNCH    = 4'd3,
        S_WAIT_BUSY = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_NEXT      = 4'd6,
        S_DONE      = 4'd7,
        S_ERROR     = 4'd8
    } sched_state_e;

endpackage

// File: rtl/scenario_scheduler.sv
// Runs a programmed table of scenario FSMs back to back, each a programmed number of times,
// gating their starts and muxing the active scenario's trigger onto the output (1-cycle lag).
module scenario_scheduler
    import types_pkg::*;
#(
    parameter int N_SCEN    = 4,
    parameter int SEQ_DEPTH = 8,
    localparam int AW       = $clog2(SEQ_DEPTH),
    localparam int IDW      = (N_SCEN > 1) ? $clog2(N_SCEN) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  input_signals_t                in_i,
    input  logic                          seq_wr_en_i,
    input  logic [AW-1:0]                 seq_wr_addr_i,
    input  seq_entry_t                    seq_wr_data_i,
    input  logic [AW:0]                   seq_len_i,
    input  logic [31:0]                   timeout_i,
    input  logic                          arm_i,
    input  logic                          abort_i,
    input  output_signals_t [N_SCEN-1:0]  scen_out_i,
    output logic [N_SCEN-1:0]             scen_start_o,
    output output_signals_t               out_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [AW-1:0]                 cur_index_o,
    output logic [7:0]                    cur_repeat_o
);

    sched_state_e      state_q;
    seq_entry_t        table_q [SEQ_DEPTH];
    logic [AW:0]       seq_len_q;
    logic [AW-1:0]     cur_index_q;
    logic [7:0]        cur_repeat_q;
    logic [IDW-1:0]    cur_id_q;
    logic [31:0]       cnt_q;
    logic [N_SCEN-1:0] scen_start_q;
    logic              trig_q;
    logic              error_q;
    logic              valid_q;
    logic              arm_q;
    logic              start_q;

    seq_entry_t        entry_d;
    output_signals_t   act_d;
    logic              arm_rise_d;
    logic              start_rise_d;
    logic [31:0]       cnt_inc_d;
    logic              tmo_d;
    logic              act_busy_d;
    logic              bad_id_d;
    logic [AW:0]       next_index_d;
    logic [N_SCEN-1:0] load_onehot_d;
    logic [N_SCEN-1:0] cur_onehot_d;
    logic              unused_act_valid;

    assign entry_d       = table_q[cur_index_q];
    assign act_d         = scen_out_i[cur_id_q];
    assign arm_rise_d    = arm_i & ~arm_q;
    assign start_rise_d  = in_i.start & ~start_q;
    // Counter saturates rather than wrapping; timeout compares against the post-increment value.
    assign cnt_inc_d     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign tmo_d         = (timeout_i != 32'd0) && (cnt_inc_d == timeout_i);
    assign act_busy_d    = (act_d.scenario_state != 8'd0);
    assign bad_id_d      = ({24'd0, entry_d.scen_id} >= 32'(N_SCEN));
    assign next_index_d  = {1'b0, cur_index_q} + (AW+1)'(1);
    assign load_onehot_d = N_SCEN'(1) << entry_d.scen_id[IDW-1:0];
    assign cur_onehot_d  = N_SCEN'(1) << cur_id_q;
    assign unused_act_valid = act_d.valid_scenario;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (seq_wr_en_i && (state_q == S_IDLE)
                     && ({1'b0, seq_wr_addr_i} < (AW+1)'(SEQ_DEPTH))) begin
            table_q[seq_wr_addr_i] <= seq_wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            seq_len_q    <= '0;
            cur_index_q  <= '0;
            cur_repeat_q <= '0;
            cur_id_q     <= '0;
            cnt_q        <= '0;
            scen_start_q <= '0;
            trig_q       <= 1'b0;
            error_q      <= 1'b0;
            valid_q      <= 1'b0;
            arm_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            arm_q        <= arm_i;
            start_q      <= in_i.start;
            valid_q      <= 1'b1;
            scen_start_q <= '0;
            trig_q       <= 1'b0;
            if (abort_i) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (arm_rise_d) begin
                            seq_len_q    <= seq_len_i;
                            error_q      <= 1'b0;
                            cur_index_q  <= '0;
                            cur_repeat_q <= '0;
                            state_q      <= (seq_len_i == '0) ? S_DONE : S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (start_rise_d) state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (bad_id_d) begin
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end else if (entry_d.rpt == 8'd0) begin
                            // Zero cur_repeat so NEXT moves straight on to the following entry.
                            cur_repeat_q <= '0;
                            state_q      <= S_NEXT;
                        end else begin
                            cur_repeat_q <= entry_d.rpt;
                            cur_id_q     <= entry_d.scen_id[IDW-1:0];
                            scen_start_q <= load_onehot_d;
                            state_q      <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: begin
                        if (act_busy_d) begin
                            trig_q  <= act_d.output_trigger;
                            cnt_q   <= '0;
                            state_q <= S_WAIT_DONE;
                        end else if (tmo_d) begin
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end else begin
                            trig_q  <= act_d.output_trigger;
                            cnt_q   <= cnt_inc_d;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (!act_busy_d) begin
                            trig_q  <= act_d.output_trigger;
                            state_q <= S_NEXT;
                        end else if (tmo_d) begin
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end else begin
                            trig_q  <= act_d.output_trigger;
                            cnt_q   <= cnt_inc_d;
                        end
                    end
                    S_NEXT: begin
                        if (cur_repeat_q > 8'd1) begin
                            cur_repeat_q <= cur_repeat_q - 8'd1;
                            scen_start_q <= cur_onehot_d;
                            state_q      <= S_LAUNCH;
                        end else if (next_index_d < seq_len_q) begin
                            cur_index_q <= next_index_d[AW-1:0];
                            state_q     <= S_LOAD;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    S_ERROR: begin
                        if (!arm_i) state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign scen_start_o         = scen_start_q;
    assign out_o.output_trigger = trig_q;
    assign out_o.scenario_state = {4'd0, state_q};
    assign out_o.valid_scenario = valid_q;
    assign busy_o  = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign done_o  = (state_q == S_DONE);
    assign error_o = error_q;
    assign cur_index_o  = cur_index_q;
    assign cur_repeat_o = cur_repeat_q;

endmodule

// File: tb/tb_scenario_scheduler.sv
// Scoreboard bench: stimulus pushes expected start/done/error events, a negedge monitor
// pops and compares them, checks the muxed trigger against stub FSMs and drives the stubs.
module tb_scenario_scheduler;
    import types_pkg::*;

    localparam int N_SCEN    = 4;
    localparam int SEQ_DEPTH = 8;
    localparam int BUSY_LEN  = 5;
    localparam int EV_S = 83;
    localparam int EV_D = 68;
    localparam int EV_E = 69;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    input_signals_t               in_s = '0;
    logic                         seq_wr_en = 1'b0;
    logic [2:0]                   seq_wr_addr = '0;
    seq_entry_t                   seq_wr_data = '0;
    logic [3:0]                   seq_len = '0;
    logic [31:0]                  timeout = '0;
    logic                         arm = 1'b0;
    logic                         abort = 1'b0;
    output_signals_t [N_SCEN-1:0] scen_out = '0;
    logic [N_SCEN-1:0]            scen_start;
    output_signals_t              out;
    logic                         busy, done, error;
    logic [2:0]                   cur_index;
    logic [7:0]                   cur_repeat;

    scenario_scheduler #(.N_SCEN(N_SCEN), .SEQ_DEPTH(SEQ_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in_s),
        .seq_wr_en_i(seq_wr_en), .seq_wr_addr_i(seq_wr_addr), .seq_wr_data_i(seq_wr_data),
        .seq_len_i(seq_len), .timeout_i(timeout), .arm_i(arm), .abort_i(abort),
        .scen_out_i(scen_out), .scen_start_o(scen_start), .out_o(out),
        .busy_o(busy), .done_o(done), .error_o(error),
        .cur_index_o(cur_index), .cur_repeat_o(cur_repeat)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_q[$];
    int start_cyc[$];
    int trig_hi = 0;
    int stub_cnt [N_SCEN];
    bit never_busy [N_SCEN];
    int active = 0;
    bit active_vld = 1'b0;
    bit err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int ev(input int kind, input int val);
        return (kind << 8) | val;
    endfunction

    task automatic record(input int got);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL event_unexpected: got %0h expected none (cycle %0d)", got, cyc);
        end else begin
            check("event", 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Monitor and stub scenario FSMs share one negedge process so their ordering is fixed.
    initial forever @(negedge clk) begin
        if (!rst_n) active_vld = 1'b0;
        check("out_trigger", 32'(out.output_trigger),
              32'(active_vld ? scen_out[active].output_trigger : 1'b0));
        if (out.output_trigger) trig_hi++;
        if (scen_start != '0) begin
            record(ev(EV_S, int'(scen_start)));
            start_cyc.push_back(cyc);
            for (int i = 0; i < N_SCEN; i++) if (scen_start[i]) active = i;
            active_vld = 1'b1;
        end
        if (done) record(ev(EV_D, 0));
        if (error && !err_prev) record(ev(EV_E, 0));
        err_prev = error;
        if (abort) active_vld = 1'b0;
        for (int i = 0; i < N_SCEN; i++) begin
            if (scen_start[i] && !never_busy[i]) stub_cnt[i] = BUSY_LEN;
            else if (stub_cnt[i] > 0) stub_cnt[i]--;
            scen_out[i].scenario_state = (stub_cnt[i] > 0) ? 8'd1 : 8'd0;
            scen_out[i].output_trigger = (stub_cnt[i] == 3) || (stub_cnt[i] == 2);
            scen_out[i].valid_scenario = 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int k = 0;
        while ((out.scenario_state[3:0] != s) && (k < 300)) begin
            tick();
            k++;
        end
        check(name, 32'(out.scenario_state[3:0]), 32'(s));
    endtask

    task automatic write_entry(input int addr, input int id, input int rpt);
        seq_wr_en = 1'b1;
        seq_wr_addr = 3'(addr);
        seq_wr_data.scen_id = 8'(id);
        seq_wr_data.rpt = 8'(rpt);
        tick();
        seq_wr_en = 1'b0;
    endtask

    task automatic arm_seq(input int len);
        seq_len = 4'(len);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_start();
        in_s.start = 1'b1;
        tick();
        in_s.start = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_state", 32'(out.scenario_state), 32'd0);
        check("rst_valid", 32'(out.valid_scenario), 32'd0);
        check("rst_flags", {29'd0, busy, done, error}, 32'd0);
        check("rst_start", 32'(scen_start), 32'd0);
        check("rst_repeat", {21'd0, cur_index, cur_repeat}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("valid_after_rst", 32'(out.valid_scenario), 32'd1);

        // Two entries: id0 twice then id1 once.
        write_entry(0, 0, 2);
        write_entry(1, 1, 1);
        exp_q.push_back(ev(EV_S, 1));
        exp_q.push_back(ev(EV_S, 1));
        exp_q.push_back(ev(EV_S, 2));
        exp_q.push_back(ev(EV_D, 0));
        start_cyc.delete();
        trig_hi = 0;
        arm_seq(2);
        check("t1_armed", 32'(out.scenario_state), 32'(S_ARMED));
        in_s.start = 1'b1;
        tick();
        in_s.start = 1'b0;
        check("t1_load", 32'(out.scenario_state), 32'(S_LOAD));
        tick();
        check("t1_launch", 32'(out.scenario_state), 32'(S_LAUNCH));
        check("t1_start_vec", 32'(scen_start), 32'd1);
        check("t1_cur_repeat", 32'(cur_repeat), 32'd2);
        // A table write while running must not disturb entry 1.
        seq_wr_en = 1'b1;
        seq_wr_addr = 3'd1;
        seq_wr_data = {8'd2, 8'd3};
        tick();
        seq_wr_en = 1'b0;
        wait_state(4'(S_DONE), "t1_done");
        check("t1_cur_index", 32'(cur_index), 32'd1);
        wait_state(4'(S_IDLE), "t1_idle");
        check("t1_nstarts", 32'(start_cyc.size()), 32'd3);
        if (start_cyc.size() == 3) begin
            check("t1_gap_repeat", 32'(start_cyc[1] - start_cyc[0]), 32'd7);
            check("t1_gap_entry", 32'(start_cyc[2] - start_cyc[1]), 32'd8);
        end
        check("t1_trig_cycles", 32'(trig_hi), 32'd6);
        tick(4);

        // Skipped entry (repeat 0) between two valid ones.
        write_entry(0, 2, 1);
        write_entry(1, 3, 0);
        write_entry(2, 1, 1);
        exp_q.push_back(ev(EV_S, 4));
        exp_q.push_back(ev(EV_S, 2));
        exp_q.push_back(ev(EV_D, 0));
        start_cyc.delete();
        arm_seq(3);
        pulse_start();
        wait_state(4'(S_DONE), "t2_done");
        check("t2_nstarts", 32'(start_cyc.size()), 32'd2);
        if (start_cyc.size() == 2)
            check("t2_gap_skip", 32'(start_cyc[1] - start_cyc[0]), 32'd10);
        tick(6);

        // Timeout with a stub that never leaves state 0.
        begin
            int wb;
            int k;
            never_busy[3] = 1'b1;
            timeout = 32'd10;
            write_entry(0, 3, 1);
            exp_q.push_back(ev(EV_S, 8));
            exp_q.push_back(ev(EV_E, 0));
            arm_seq(1);
            pulse_start();
            wait_state(4'(S_WAIT_BUSY), "t3_wait_busy");
            wb = cyc;
            k = 0;
            while (!error && k < 60) begin
                tick();
                k++;
            end
            check("t3_timeout_cycles", 32'(cyc - wb), 32'd10);
            check("t3_state_err", 32'(out.scenario_state), 32'(S_ERROR));
            check("t3_start_zero", 32'(scen_start), 32'd0);
            tick();
            check("t3_idle", 32'(out.scenario_state), 32'(S_IDLE));
            check("t3_err_sticky", 32'(error), 32'd1);
            timeout = 32'd0;
            never_busy[3] = 1'b0;
        end

        // Out-of-range scenario id.
        write_entry(0, 5, 1);
        exp_q.push_back(ev(EV_E, 0));
        arm_seq(1);
        check("t4_err_cleared", 32'(error), 32'd0);
        pulse_start();
        check("t4_state_err", 32'(out.scenario_state), 32'(S_ERROR));
        check("t4_err_set", 32'(error), 32'd1);
        wait_state(4'(S_IDLE), "t4_idle");

        // Abort while the muxed trigger is high.
        write_entry(0, 1, 1);
        exp_q.push_back(ev(EV_S, 2));
        arm_seq(1);
        pulse_start();
        tick(3);
        check("t5_trig_high", 32'(out.output_trigger), 32'd1);
        check("t5_wait_done", 32'(out.scenario_state), 32'(S_WAIT_DONE));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_trig_low", 32'(out.output_trigger), 32'd0);
        check("t5_state_idle", 32'(out.scenario_state), 32'(S_IDLE));
        check("t5_no_done", 32'(done), 32'd0);
        tick(8);

        // Asynchronous reset mid-WAIT_DONE.
        write_entry(0, 0, 1);
        exp_q.push_back(ev(EV_S, 1));
        arm_seq(1);
        pulse_start();
        tick(3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_trig", 32'(out.output_trigger), 32'd0);
        check("t6_rst_state", 32'(out.scenario_state), 32'd0);
        check("t6_rst_flags", {28'd0, scen_start == '0 ? 1'b0 : 1'b1, busy, done, error}, 32'd0);
        check("t6_rst_repeat", 32'(cur_repeat), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(8);
        // Cleared table: entry 0 is {0,0}, so it is skipped with no start.
        exp_q.push_back(ev(EV_D, 0));
        arm_seq(1);
        pulse_start();
        wait_state(4'(S_DONE), "t6_zero_table_done");
        tick(3);
        exp_q.push_back(ev(EV_D, 0));
        seq_len = 4'd0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t6_len0_done", 32'(done), 32'd1);
        tick();
        check("t6_len0_idle", 32'(out.scenario_state), 32'(S_IDLE));
        tick(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
